uart_stim_tx: RTL and testbench

- Synthesizable 8N1 UART transmitter with a byte-wide valid/ready input and an internal FIFO.
- Drives the SoC `i_uart_rx` pin in simulation benches, replacing the constant-1 tie-off. It is the transmit-side counterpart to the bench UART decoder that monitors `o_uart_tx`.
- Also usable on-board as a host-side stimulus source for loopback tests.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_stim_tx.sv | 154 +++++++++++++++
 tb/tb_uart_stim_tx.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART stimulus transmitter: state encoding,
// data width and the baud divisor helper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned uart_divisor(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// The empty flag is registered, so a write into an empty FIFO becomes visible one clock later.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = UART_DATA_BITS,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             empty_q, empty_d;
    logic             ptr_equal;
    logic             do_wr, do_rd;

    assign ptr_equal = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr     = wr_en & ~full;
    assign do_rd     = rd_en & ~ptr_equal;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
        empty_d  = ptr_equal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign empty   = empty_q;
    assign level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_stim_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; o_tx comes straight from a flop
// and frames queue back to back with no idle gap.
module uart_stim_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int unsigned DIVISOR = uart_divisor(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CNT_W   = $clog2(DIVISOR);
    localparam int unsigned BIT_W   = $clog2(UART_DATA_BITS);

    if (DIVISOR < 4) begin : g_bad_divisor
        $error("uart_stim_tx: baud divisor must be at least 4");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_stim_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e                state_q, state_d;
    logic [CNT_W-1:0]           baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]           bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                       tx_q, tx_d;
    logic                       ready_en_q;
    logic                       baud_done;
    logic                       pop;

    logic [UART_DATA_BITS-1:0]  fifo_rd_data;
    logic                       fifo_full;
    logic                       fifo_empty;

    // Held low through reset so nothing is accepted until the first edge after release.
    assign o_ready = ready_en_q & ~fifo_full;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (i_valid & o_ready),
        .wr_data (i_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_level)
    );

    assign baud_done = (baud_cnt_q == CNT_W'(DIVISOR - 1));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_cnt_d = baud_done ? '0 : baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_d    = fifo_rd_data;
                    baud_cnt_d = '0;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (bit_idx_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        shreg_d   = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
                        tx_d      = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (bit_idx_q == BIT_W'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_rd_data;
                            state_d = ST_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            ready_en_q <= 1'b1;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: three instances (10-clock bits with 1 and 2 stop bits,
// and default parameters) checked against a line-level frame model and a UART decoder.
module tb_uart_stim_tx;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic [7:0] data0 = '0, data1 = '0, data2 = '0;
    logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
    logic       ready0, ready1, ready2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [4:0] level0, level1, level2;

    uart_stim_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_a), .i_data(data0), .i_valid(valid0),
        .o_ready(ready0), .o_tx(tx0), .o_busy(busy0), .o_level(level0));

    uart_stim_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_b), .i_data(data1), .i_valid(valid1),
        .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_level(level1));

    uart_stim_tx dut2 (
        .clk(clk), .rst_n(rst_b), .i_data(data2), .i_valid(valid2),
        .o_ready(ready2), .o_tx(tx2), .o_busy(busy2), .o_level(level2));

    function automatic logic line(input int sel);
        case (sel)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return ready0;
            1:       return ready1;
            default: return ready2;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [4:0] level_of(input int sel);
        case (sel)
            0:       return level0;
            1:       return level1;
            default: return level2;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0:       begin valid0 = v; data0 = d; end
            1:       begin valid1 = v; data1 = d; end
            default: begin valid2 = v; data2 = d; end
        endcase
    endtask

    // Returns at the negedge right after the accepting edge.
    task automatic push(input int sel, input logic [7:0] d);
        int g = 0;
        drive(sel, 1'b1, d);
        while (!ready_of(sel) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout sel=%0d: ready stayed %b, required 1", sel, ready_of(sel));
        end
        @(negedge clk);
        drive(sel, 1'b0, d);
    endtask

    // Ideal line level k clocks after the accepting edge of the first byte:
    // idle until k=2, then contiguous frames of start, 8 data LSB first, stop bits.
    function automatic logic exp_tx(input int k, input bq_t q, input int div, input int nstop);
        int n, b, fr, bi, fl;
        if (k < 2) return 1'b1;
        fl = 9 + nstop;
        n  = k - 2;
        b  = n / div;
        fr = b / fl;
        bi = b % fl;
        if (fr >= q.size()) return 1'b1;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return q[fr][bi-1];
        return 1'b1;
    endfunction

    task automatic check_wave(input string name, input int sel, input int t, input int kto,
                              input bq_t q, input int div, input int nstop);
        int   k, end_k;
        logic e, eb;
        end_k = 2 + q.size() * (9 + nstop) * div;
        while (cyc < t + kto) begin
            @(negedge clk);
            k  = cyc - t;
            e  = exp_tx(k, q, div, nstop);
            eb = (k >= 1) && (k < end_k);
            n_cmp++;
            if (line(sel) !== e) begin
                n_err++;
                $display("FAIL %s_tx k=%0d: got %b, required %b", name, k, line(sel), e);
            end
            n_cmp++;
            if (busy_of(sel) !== eb) begin
                n_err++;
                $display("FAIL %s_busy k=%0d: got %b, required %b", name, k, busy_of(sel), eb);
            end
        end
    endtask

    task automatic uart_rx(input int sel, input int div, input int nstop, input int tmo,
                           output logic [7:0] b, output bit ok);
        int g = 0;
        ok = 1'b1;
        b  = '0;
        while (line(sel) !== 1'b0 && g < tmo) begin
            @(negedge clk);
            g++;
        end
        if (g >= tmo) begin
            ok = 1'b0;
            return;
        end
        repeat (div / 2) @(negedge clk);
        if (line(sel) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = line(sel);
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (div) @(negedge clk);
            if (line(sel) !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 8'hFF);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (line(s) !== 1'b1) begin n_err++; $display("FAIL reset_tx sel=%0d: got %b, required 1", s, line(s)); end
            n_cmp++;
            if (ready_of(s) !== 1'b0) begin n_err++; $display("FAIL reset_ready sel=%0d: got %b, required 0", s, ready_of(s)); end
            n_cmp++;
            if (busy_of(s) !== 1'b0) begin n_err++; $display("FAIL reset_busy sel=%0d: got %b, required 0", s, busy_of(s)); end
            n_cmp++;
            if (level_of(s) !== 5'd0) begin n_err++; $display("FAIL reset_level sel=%0d: got %0d, required 0", s, level_of(s)); end
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (ready_of(s) !== 1'b0) begin n_err++; $display("FAIL release_ready_early sel=%0d: got %b, required 0", s, ready_of(s)); end
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (ready_of(s) !== 1'b1) begin n_err++; $display("FAIL release_ready sel=%0d: got %b, required 1", s, ready_of(s)); end
            n_cmp++;
            if (level_of(s) !== 5'd0 || busy_of(s) !== 1'b0) begin
                n_err++;
                $display("FAIL release_idle sel=%0d: level %0d busy %b, required 0 0", s, level_of(s), busy_of(s));
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        bq_t q;
        int  t;
        q = '{8'h55};
        push(0, 8'h55);
        t = cyc;
        check_wave("single", 0, t, 110, q, 10, 1);
    endtask

    task automatic test_back_to_back();
        bq_t q;
        int  t;
        q = '{8'h00, 8'hFF};
        push(0, 8'h00);
        t = cyc;
        push(0, 8'hFF);
        check_wave("b2b", 0, t, 210, q, 10, 1);
    endtask

    task automatic test_fill();
        int acc = 0, t0 = 0, guard = 0, maxlvl = 0, npop, explvl, nrdy0 = 0;
        logic will;
        fork
            begin
                drive(0, 1'b1, 8'h00);
                while (acc < 20 && guard < 4000) begin
                    will = ready_of(0);
                    @(negedge clk);
                    guard++;
                    if (will) begin
                        if (acc == 0) t0 = cyc;
                        acc++;
                        drive(0, 1'b1, 8'(acc));
                    end
                    npop = (acc > 0 && cyc >= t0 + 2) ? (cyc - t0 - 2) / 100 + 1 : 0;
                    if (npop > acc) npop = acc;
                    explvl = acc - npop;
                    if (int'(level_of(0)) > maxlvl) maxlvl = int'(level_of(0));
                    if (!ready_of(0)) nrdy0++;
                    n_cmp++;
                    if (level_of(0) !== 5'(explvl)) begin
                        n_err++;
                        $display("FAIL fill_level cyc=%0d: got %0d, required %0d", cyc, level_of(0), explvl);
                    end
                    n_cmp++;
                    if (ready_of(0) !== (explvl < 16)) begin
                        n_err++;
                        $display("FAIL fill_ready cyc=%0d: got %b, required %b", cyc, ready_of(0), explvl < 16);
                    end
                end
                drive(0, 1'b0, 8'h00);
            end
            begin
                logic [7:0] b;
                bit ok;
                for (int j = 0; j < 20; j++) begin
                    uart_rx(0, 10, 1, 500, b, ok);
                    n_cmp++;
                    if (!ok || b !== 8'(j)) begin
                        n_err++;
                        $display("FAIL fill_byte %0d: got %h ok=%0d, required %h ok=1", j, b, ok, 8'(j));
                    end
                end
            end
        join
        n_cmp++;
        if (maxlvl != 16) begin n_err++; $display("FAIL fill_max_level: got %0d, required 16", maxlvl); end
        n_cmp++;
        if (nrdy0 == 0) begin n_err++; $display("FAIL fill_backpressure: not-ready cycles %0d, required >0", nrdy0); end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (busy_of(0) !== 1'b0) begin n_err++; $display("FAIL fill_drained_busy: got %b, required 0", busy_of(0)); end
    endtask

    task automatic test_stop2();
        bq_t q;
        int  t;
        q = '{8'hA3};
        push(1, 8'hA3);
        t = cyc;
        check_wave("stop2", 1, t, 120, q, 10, 2);
    endtask

    task automatic test_reset_mid();
        bq_t q;
        int  t, bad_tx = 0, bad_busy = 0;
        push(0, 8'h00);
        t = cyc;
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        while (cyc < t + 2 + 35) @(negedge clk);
        n_cmp++;
        if (line(0) !== 1'b0) begin n_err++; $display("FAIL midreset_pre_tx: got %b, required 0", line(0)); end
        n_cmp++;
        if (level_of(0) !== 5'd3) begin n_err++; $display("FAIL midreset_pre_level: got %0d, required 3", level_of(0)); end
        #1 rst_a = 1'b0;
        #1;
        n_cmp++;
        if (line(0) !== 1'b1) begin n_err++; $display("FAIL midreset_tx: got %b, required 1", line(0)); end
        n_cmp++;
        if (level_of(0) !== 5'd0) begin n_err++; $display("FAIL midreset_level: got %0d, required 0", level_of(0)); end
        n_cmp++;
        if (busy_of(0) !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b, required 0", busy_of(0)); end
        n_cmp++;
        if (ready_of(0) !== 1'b0) begin n_err++; $display("FAIL midreset_ready: got %b, required 0", ready_of(0)); end
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (line(0) !== 1'b1) bad_tx++;
            if (busy_of(0) !== 1'b0) bad_busy++;
        end
        n_cmp++;
        if (bad_tx != 0) begin n_err++; $display("FAIL postreset_quiet_tx: %0d active cycles, required 0", bad_tx); end
        n_cmp++;
        if (bad_busy != 0) begin n_err++; $display("FAIL postreset_quiet_busy: %0d busy cycles, required 0", bad_busy); end
        q = '{8'h5A};
        push(0, 8'h5A);
        t = cyc;
        check_wave("postreset", 0, t, 110, q, 10, 1);
    endtask

    task automatic test_random();
        bq_t sb;
        fork
            begin
                logic [7:0] d;
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 120)) @(negedge clk);
                    d = 8'($urandom);
                    sb.push_back(d);
                    push(0, d);
                end
            end
            begin
                logic [7:0] b, e;
                bit ok;
                for (int i = 0; i < 8; i++) begin
                    uart_rx(0, 10, 1, 2000, b, ok);
                    e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                    n_cmp++;
                    if (!ok || b !== e) begin
                        n_err++;
                        $display("FAIL random_byte %0d: got %h ok=%0d, required %h ok=1", i, b, ok, e);
                    end
                end
            end
        join
        repeat (20) @(negedge clk);
    endtask

    task automatic test_loopback();
        string msg = "Hello\n";
        string got = "";
        fork
            begin
                for (int i = 0; i < msg.len(); i++) push(2, msg[i]);
            end
            begin
                logic [7:0] b;
                bit ok;
                for (int i = 0; i < msg.len(); i++) begin
                    uart_rx(2, 434, 1, 3000, b, ok);
                    n_cmp++;
                    if (!ok) begin n_err++; $display("FAIL loopback_frame %0d: framing ok=%0d, required 1", i, ok); end
                    got = {got, $sformatf("%c", b)};
                end
            end
        join
        $write("loopback decoder: %s", got);
        n_cmp++;
        if (got != msg) begin n_err++; $display("FAIL loopback_string: got \"%s\", required \"%s\"", got, msg); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_stop2();
        test_reset_mid();
        test_random();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
